// File: rtl/pool2d_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pool2d_stream
//
// Streaming stride-2 pooling engine. Pixels arrive in raster order on a
// valid/ready input; pooled results leave in raster order on a valid/ready
// output. Each frame selects its own size, window mode and operation:
//   cfg_k3=1 : 3x3 window, pad 1 (row/col -1 read as 0), max
//   cfg_k3=0 : 2x2 window, no pad, max (cfg_avg=0) or rounded average (cfg_avg=1)
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle frame start, samples cfg_* while idle
//   cfg_width/height     image size W, H (even, non-zero, <= MAX_W/MAX_H)
//   cfg_k3, cfg_avg      window mode / operation
//   busy, done, err      frame in progress, end-of-frame pulse, config rejected
//   s_valid/ready/data   input pixel stream
//   m_valid/ready/data   pooled output stream, m_last flags the final output
//
// The single line buffer holds, per column, a vertical partial result:
//   3x3: even row r>0 stores max(buf, pix); row 0 stores pix (pad row -1 = 0);
//        odd rows consume max(buf, pix) and store pix, which is the shared
//        top row of the next window row.
//   2x2: even rows store pix; odd rows consume buf+pix (avg) or max(buf, pix).
// The horizontal reduction runs only on odd rows, using two column registers.
// -----------------------------------------------------------------------------
module pool2d_stream #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 128,
    parameter int MAX_H  = 128,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic              cfg_k3,
    input  logic              cfg_avg,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int COL_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t state_q, state_d;

    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic              k3_q, k3_d;
    logic              avg_q, avg_d;
    logic              err_q, err_d;
    logic [DATA_W+1:0] hacc_q, hacc_d;     // running horizontal result (sum needs 2 extra bits)
    logic [DATA_W-1:0] hcarry_q, hcarry_d; // 3x3: previous odd column, shared by adjacent windows
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;

    logic [DATA_W-1:0] lb_mem [MAX_W];

    logic              cfg_ok;
    logic              cfg_load;
    logic              xfer;
    logic              last_col, last_row;
    logic              row_odd, col_odd;
    logic [COL_W-1:0]  lb_idx;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] lb_wdata;
    logic [DATA_W-1:0] v_max;
    logic [DATA_W+1:0] v_col;
    logic [DATA_W+1:0] avg_sum;
    logic [DATA_W-1:0] result;

    // ---------------------------------------------------------------- control
    assign cfg_ok = (cfg_width  != '0) && !cfg_width[0]  && (cfg_width  <= DIM_W'(MAX_W)) &&
                    (cfg_height != '0) && !cfg_height[0] && (cfg_height <= DIM_W'(MAX_H));
    assign cfg_load = (state_q == S_IDLE) && start;
    assign xfer     = s_valid && s_ready;
    assign last_col = (col_q == width_q  - 1'b1);
    assign last_row = (row_q == height_q - 1'b1);
    assign row_odd  = row_q[0];
    assign col_odd  = col_q[0];

    // FSM: state register
    // NOTE: every flop uses a non-blocking assignment so all registers update
    // together at the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next-state logic
    // NOTE: default assignment first, so no path through the block leaves
    // state_d unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = cfg_ok ? S_RUN : S_DONE;
            S_RUN:   if (xfer && last_row && last_col) state_d = S_DRAIN;
            S_DRAIN: if (m_valid_q && m_ready && m_last_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
        done    = (state_q == S_DONE);
        err     = (state_q == S_DONE) && err_q;
        s_ready = (state_q == S_RUN) && (!m_valid_q || m_ready);
    end

    // --------------------------------------------------------------- datapath
    assign lb_idx = col_q[COL_W-1:0];
    assign lb_rd  = lb_mem[lb_idx];
    assign v_max  = umax(lb_rd, s_data);

    // Vertical column result on odd rows.
    assign v_col = (avg_q && !k3_q) ? ({2'b00, lb_rd} + {2'b00, s_data})
                                    : {2'b00, v_max};

    // 3x3 even rows below row 0 fold into the stored odd row above.
    assign lb_wdata = (k3_q && !row_odd && (row_q != '0)) ? v_max : s_data;

    assign avg_sum = hacc_q + v_col + (DATA_W+2)'(2);
    assign result  = (avg_q && !k3_q) ? avg_sum[DATA_W+1:2]
                                      : umax(hacc_q[DATA_W-1:0], v_col[DATA_W-1:0]);

    always_comb begin
        width_d   = width_q;
        height_d  = height_q;
        k3_d      = k3_q;
        avg_d     = avg_q;
        err_d     = err_q;
        row_d     = row_q;
        col_d     = col_q;
        hacc_d    = hacc_q;
        hcarry_d  = hcarry_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        if (cfg_load) begin
            width_d  = cfg_width;
            height_d = cfg_height;
            k3_d     = cfg_k3;
            avg_d    = cfg_avg;
            err_d    = !cfg_ok;
            row_d    = '0;
            col_d    = '0;
        end else if (xfer) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (xfer && row_odd) begin
            if (!col_odd) begin
                // Column -1 of a 3x3 window is padding: start fresh at column 0.
                hacc_d = (k3_q && (col_q != '0))
                       ? {2'b00, umax(hcarry_q, v_col[DATA_W-1:0])}
                       : v_col;
            end else begin
                hcarry_d = v_col[DATA_W-1:0];
            end
        end

        // The output slot is free whenever a pixel is accepted (s_ready gating).
        if (xfer && row_odd && col_odd) begin
            m_valid_d = 1'b1;
            m_data_d  = result;
            m_last_d  = last_row && last_col;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q   <= '0;
            height_q  <= '0;
            k3_q      <= 1'b0;
            avg_q     <= 1'b0;
            err_q     <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            hacc_q    <= '0;
            hcarry_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            width_q   <= width_d;
            height_q  <= height_d;
            k3_q      <= k3_d;
            avg_q     <= avg_d;
            err_q     <= err_d;
            row_q     <= row_d;
            col_q     <= col_d;
            hacc_q    <= hacc_d;
            hcarry_q  <= hcarry_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    // NOTE: the line buffer has no reset; every entry is written before it is
    // read within a frame, and row-0 padding is decided by the row counter.
    always_ff @(posedge clk) begin
        if (xfer) lb_mem[lb_idx] <= lb_wdata;
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
- Parametrised successor to the fixed 128x128 3x3/stride-2 max-pooling engine.
- Consumes a raster-order pixel stream with valid/ready and emits a raster-order pooled stream with valid/ready.
- Image dimensions, window mode (3x3 pad-1 or 2x2 no-pad, both stride 2) and operation (max or average) are selected per frame.
- Sits between the feature-map reader and the result writer, replacing address-driven memory ports.

Parameters:
- DATA_W, 8, pixel width in bits (unsigned).
- MAX_W, 128, maximum image width; sizes the line buffers.
- MAX_H, 128, maximum image height.
- DIM_W, 8, width of the cfg_width and cfg_height ports; must hold MAX_W and MAX_H.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle frame start; configuration is sampled on this cycle.
- cfg_width, in, DIM_W, image width W.
- cfg_height, in, DIM_W, image height H.
- cfg_k3, in, 1, 1 = 3x3 window with pad 1; 0 = 2x2 window with no pad.
- cfg_avg, in, 1, 1 = average (2x2 only); 0 = max.
- busy, out, 1, frame in progress.
- done, out, 1, single-cycle pulse at frame end.
- err, out, 1, valid only with done; 1 = configuration rejected.
- s_valid, in, 1, input pixel valid.
- s_ready, out, 1, input pixel accept.
- s_data, in, DATA_W, input pixel, raster order, row 0 col 0 first.
- m_valid, out, 1, output pixel valid.
- m_ready, in, 1, output accept.
- m_data, out, DATA_W, pooled pixel.
- m_last, out, 1, marks the final output of the frame.

Behaviour:
- Reset values: busy=0, done=0, err=0, s_ready=0, m_valid=0, m_data=0, m_last=0. Reset also clears the state machine, all counters and all window registers. Reset mid-frame aborts the frame; no done pulse is issued.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, latch the configuration.
  - If W or H is 0, odd, or exceeds MAX_W/MAX_H: go to DONE with err=1 and accept no pixels.
  - Otherwise go to RUN and set busy=1.
  - If start arrives while busy, ignore it.
- RUN:
  - s_ready = !m_valid || m_ready.
  - A pixel transfers when s_valid && s_ready. Row and column counters advance only on a transfer.
  - Once pixel (H-1, W-1) transfers, go to DRAIN.
- DRAIN: wait until the last output is accepted (m_valid && m_ready && m_last), then go to DONE.
- DONE: assert done for one cycle, clear busy, return to IDLE. err is held with done.
- Output geometry: Wo=W/2, Ho=H/2. Exactly Wo*Ho outputs per frame.
- Output (i, j) is produced when input pixel (2i+1, 2j+1) transfers. m_valid rises on the next cycle (latency 1), with m_data registered. m_data and m_last stay stable while m_valid=1 and m_ready=0.
- 3x3 mode:
  - Window covers rows 2i-1..2i+1 and columns 2j-1..2j+1.
  - Row -1 and column -1 read as 0.
  - Result is the unsigned max of the 9 values.
- 2x2 mode:
  - Window covers rows 2i..2i+1 and columns 2j..2j+1.
  - cfg_avg=0: result is the max of the 4 values.
  - cfg_avg=1: result is (sum + 2) >> 2. The sum uses DATA_W+2 bits; the result is truncated to DATA_W bits.
- cfg_avg is ignored in 3x3 mode; max is used.
- Storage budget: at most 2 line buffers of MAX_W x DATA_W, plus column registers. Implement the line buffers as per-column partial reductions, not full-window re-reads.
- Line buffers need no clearing between frames. Row 0 padding comes from the counters, not from buffer contents.
- m_last is asserted on output (Ho-1, Wo-1).

Test Plan:
- 4x4 frame, pixels 0..15 in raster order, 3x3 max, m_ready=1 -> outputs 5, 7, 13, 15; m_last on the 4th output; done follows; 16 pixels accepted with no stalls.
- Same frame in 2x2 average mode -> outputs 3, 5, 11, 13 (e.g. (0+1+4+5+2)>>2 = 3). Same frame in 2x2 max mode -> 5, 7, 13, 15.
- 128x128 random frame, 3x3 max, m_ready toggling randomly -> 4096 outputs matching the reference model; m_data stable while stalled; s_ready=0 whenever m_valid=1 and m_ready=0.
- start with W=6, H=5 -> done=1 and err=1 on the same cycle; s_ready stays 0; no outputs.
- Assert rst after 10 pixels of a 8x8 frame -> all outputs reset; a following 4x4 frame produces correct results. A start pulse issued while busy has no effect.
- All-255 8x2 frame in 3x3 mode -> four outputs of 255; the zero padding does not lower the max. Same frame in 2x2 average mode -> 255 (no overflow).
